// File: rtl/dphy_gearbox_fifo.sv
// dphy_gearbox_fifo: dual-clock IN_W-to-OUT_W gearbox FIFO with Gray pointers; define DPHY_GEARBOX_MSB_FIRST_EN for MSB-first slices
module dphy_gearbox_fifo #(
  parameter int IN_W      = 8,
  parameter int OUT_W     = 2,
  parameter int DEPTH     = 8,
  parameter int START_LVL = 4
) (
  input  logic             reset_n,
  input  logic             wclk,
  input  logic             rclk,
  input  logic [IN_W-1:0]  wdata,
  input  logic             wen,
  output logic             wfull,
  output logic             overflow,
  output logic [OUT_W-1:0] q,
  output logic             q_valid,
  output logic             underrun
);
  localparam int SLICES = IN_W / OUT_W;
  localparam int AW     = $clog2(DEPTH);
  localparam int SW     = $clog2(SLICES);
  typedef enum logic {IDLE, RUN} state_t;
  function automatic logic [AW:0] g2b(input logic [AW:0] g);
    for (int i = AW - 1; i >= 0; i--) g[i] = g[i] ^ g[i+1];
    return g;
  endfunction
  logic [IN_W-1:0]  mem_q [DEPTH];
  logic [AW:0]      wp_bin_q, wp_bin_d, wp_gray_q, wp_gray_d, rp_gray_w1_q, rp_gray_w2_q, rp_bin_w;
  logic             overflow_q, overflow_d, wr;
  logic [AW:0]      wp_gray_r1_q, wp_gray_r2_q, level, rp_bin_q, rp_bin_d, rp_gray_q, rp_gray_d;
  logic [SW-1:0]    idx_q, idx_d;
  logic [IN_W-1:0]  rd_word;
  logic [OUT_W-1:0] slice, q_q, q_d;
  logic             q_valid_q, q_valid_d, underrun_q, underrun_d, last;
  state_t           state_q, state_d;
  assign overflow = overflow_q;
  assign q        = q_q;
  assign q_valid  = q_valid_q;
  assign underrun = underrun_q;
  // write side: full detection against synchronised read pointer, pointer advance, sticky overflow
  always_comb begin
    rp_bin_w   = g2b(rp_gray_w2_q);
    wfull      = (wp_bin_q - rp_bin_w) == (AW+1)'(DEPTH);
    wr         = wen & ~wfull;
    wp_bin_d   = wr ? wp_bin_q + (AW+1)'(1) : wp_bin_q;
    wp_gray_d  = wp_bin_d ^ (wp_bin_d >> 1);
    overflow_d = overflow_q | (wen & wfull);
  end
  // write-domain state and two-flop read-pointer synchroniser
  always_ff @(posedge wclk or negedge reset_n)
    if (!reset_n) {wp_bin_q, wp_gray_q, rp_gray_w1_q, rp_gray_w2_q, overflow_q} <= '0;
    else begin
      wp_bin_q     <= wp_bin_d;
      wp_gray_q    <= wp_gray_d;
      rp_gray_w1_q <= rp_gray_q;
      rp_gray_w2_q <= rp_gray_w1_q;
      overflow_q   <= overflow_d;
    end
  // storage array; contents need no reset since pointers gate visibility
  always_ff @(posedge wclk)
    if (wr) mem_q[wp_bin_q[AW-1:0]] <= wdata;
  // read side: level, slice selection and IDLE/RUN next-state
  always_comb begin
    level   = g2b(wp_gray_r2_q) - rp_bin_q;
    rd_word = mem_q[rp_bin_q[AW-1:0]];
`ifdef DPHY_GEARBOX_MSB_FIRST_EN
    slice   = rd_word[IN_W - OUT_W - OUT_W*int'(idx_q) +: OUT_W];
`else
    slice   = rd_word[OUT_W*int'(idx_q) +: OUT_W];
`endif
    last       = idx_q == SW'(SLICES - 1);
    state_d    = state_q;
    idx_d      = idx_q;
    rp_bin_d   = rp_bin_q;
    underrun_d = underrun_q;
    if (state_q == IDLE) begin
      idx_d = '0;
      if (level >= (AW+1)'(START_LVL)) state_d = RUN;
    end else begin
      idx_d = idx_q + SW'(1);
      if (last) begin
        rp_bin_d = rp_bin_q + (AW+1)'(1);
        if (level == (AW+1)'(1)) begin
          state_d    = IDLE;
          underrun_d = 1'b1;
        end
      end
    end
    rp_gray_d = rp_bin_d ^ (rp_bin_d >> 1);
    q_valid_d = state_q == RUN;
    q_d       = q_valid_d ? slice : '0;
  end
  // read-domain state and two-flop write-pointer synchroniser
  always_ff @(posedge rclk or negedge reset_n)
    if (!reset_n) begin
      {wp_gray_r1_q, wp_gray_r2_q, rp_bin_q, rp_gray_q, idx_q, q_q, q_valid_q, underrun_q} <= '0;
      state_q <= IDLE;
    end else begin
      wp_gray_r1_q <= wp_gray_q;
      wp_gray_r2_q <= wp_gray_r1_q;
      rp_bin_q     <= rp_bin_d;
      rp_gray_q    <= rp_gray_d;
      idx_q        <= idx_d;
      q_q          <= q_d;
      q_valid_q    <= q_valid_d;
      underrun_q   <= underrun_d;
      state_q      <= state_d;
    end
endmodule

// File: tb/tb_dphy_gearbox_fifo.sv
// tb_dphy_gearbox_fifo: scoreboard bench for the dual-clock gearbox FIFO
`timescale 1ns/100ps
module tb_dphy_gearbox_fifo;
  localparam int IN_W = 8, OUT_W = 2, DEPTH = 8, START_LVL = 4, SLICES = IN_W / OUT_W;
  logic reset_n = 1'b0, wclk = 1'b0, rclk = 1'b0, rclk_en = 1'b1, wen = 1'b0;
  logic [IN_W-1:0] wdata = '0;
  logic wfull, overflow, q_valid, underrun;
  logic [OUT_W-1:0] q;
  logic [OUT_W-1:0] sb [$];
  int n_cmp = 0, n_err = 0, vcount = 0;
  dphy_gearbox_fifo #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .START_LVL(START_LVL)) dut (
    .reset_n(reset_n), .wclk(wclk), .rclk(rclk), .wdata(wdata), .wen(wen),
    .wfull(wfull), .overflow(overflow), .q(q), .q_valid(q_valid), .underrun(underrun)
  );
  always #5 wclk = ~wclk;
  always #13.5 if (rclk_en) rclk = ~rclk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic push_word(input logic [IN_W-1:0] w);
    logic [OUT_W-1:0] s;
    for (int k = 0; k < SLICES; k++) begin
`ifdef DPHY_GEARBOX_MSB_FIRST_EN
      s = OUT_W'(w >> (IN_W - OUT_W*(k + 1)));
`else
      s = OUT_W'(w >> (OUT_W*k));
`endif
      sb.push_back(s);
    end
  endtask
  task automatic put(input logic [IN_W-1:0] w, input bit keep);
    @(negedge wclk);
    wen = 1'b1;
    wdata = w;
    if (keep) push_word(w);
  endtask
  task automatic wstop();
    @(negedge wclk);
    wen = 1'b0;
  endtask
  task automatic do_reset();
    wen = 1'b0;
    #1.3 reset_n = 1'b0;
    sb.delete();
    #20;
    @(negedge wclk);
    #1.3 reset_n = 1'b1;
  endtask
  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || q_valid) && n < 3000) begin
      @(posedge rclk);
      #1;
      n++;
    end
    chk({tag, "_drain_left"}, 32'(sb.size()), 0);
    chk({tag, "_qv_end"}, 32'(q_valid), 0);
  endtask
  always @(negedge rclk) begin : mon
    logic [31:0] e;
    if (q_valid) begin
      vcount++;
      e = (sb.size() != 0) ? 32'(sb.pop_front()) : 32'hDEAD;
      chk("q_slice", 32'(q), e);
    end else chk("q_idle", 32'(q), 0);
  end
  initial begin
    int v0, n, cyc;
    #1;
    chk("rst_wfull", 32'(wfull), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_q", 32'(q), 0);
    chk("rst_qvalid", 32'(q_valid), 0);
    chk("rst_underrun", 32'(underrun), 0);
    #20;
    @(negedge wclk);
    #1.3 reset_n = 1'b1;
    v0 = vcount;
    put(8'hE4, 1); put(8'h1B, 1); put(8'hFF, 1); put(8'h00, 1); wstop();
    drain("t1");
    chk("t1_len", 32'(vcount - v0), 16);
    chk("t1_underrun", 32'(underrun), 1);
    do_reset();
    chk("t2_underrun_clr", 32'(underrun), 0);
    v0 = vcount;
    for (int i = 0; i < 3; i++) put(8'($urandom), 1);
    wstop();
    repeat (20) @(posedge rclk);
    #1;
    chk("t2_hold_qv", 32'(q_valid), 0);
    chk("t2_hold_len", 32'(vcount - v0), 0);
    put(8'($urandom), 1); wstop();
    drain("t2");
    chk("t2_len", 32'(vcount - v0), 16);
    do_reset();
    rclk_en = 1'b0;
    #30;
    v0 = vcount;
    for (int i = 0; i < 8; i++) begin
      put(8'($urandom), 1);
      if (i == 6) chk("t3_not_full7", 32'(wfull), 0);
    end
    put(8'hA5, 0);
    chk("t3_full", 32'(wfull), 1);
    chk("t3_ovf_before", 32'(overflow), 0);
    wstop();
    chk("t3_ovf", 32'(overflow), 1);
    rclk_en = 1'b1;
    drain("t3");
    chk("t3_len", 32'(vcount - v0), 32);
    chk("t3_wfull_clr", 32'(wfull), 0);
    do_reset();
    n = 0;
    cyc = 0;
    while (n < 1000 && cyc < 40000) begin
      @(negedge wclk);
      cyc++;
      if ($urandom_range(1) == 1 && !wfull) begin
        wen = 1'b1;
        wdata = 8'($urandom);
        push_word(wdata);
        n++;
      end else wen = 1'b0;
    end
    wstop();
    chk("t4_words", 32'(n), 1000);
    drain("t4");
    chk("t4_ovf", 32'(overflow), 0);
    do_reset();
    for (int i = 0; i < 4; i++) put(8'($urandom), 1);
    wstop();
    n = 0;
    while (!q_valid && n < 100) begin
      @(posedge rclk);
      #1;
      n++;
    end
    chk("t5_started", 32'(q_valid), 1);
    repeat (3) @(posedge rclk);
    #2.1 reset_n = 1'b0;
    #1;
    sb.delete();
    chk("t5_rst_qv", 32'(q_valid), 0);
    chk("t5_rst_q", 32'(q), 0);
    chk("t5_rst_wfull", 32'(wfull), 0);
    chk("t5_rst_underrun", 32'(underrun), 0);
    #20;
    @(negedge wclk);
    #1.3 reset_n = 1'b1;
    v0 = vcount;
    put(8'hE4, 1); put(8'hE4, 1); put(8'hE4, 1); put(8'hE4, 1); wstop();
    drain("t5");
    chk("t5_len", 32'(vcount - v0), 16);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
